par2ser_stream: RTL and testbench
=================================

PAR2SER_STREAM -- requirements
Module: par2ser_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the parallel word width in bits (DW >= 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick, input, 1, shift enable; one serial bit is emitted per clk edge with tick=1.
REQ-005 SHALL have port in_valid, input, 1, upstream word present.
REQ-006 SHALL have port in_data, input, DW, upstream parallel word.
REQ-007 SHALL have port in_ready, output, 1, holding register empty; combinational from registered state only.
REQ-008 SHALL have port abort, input, 1, synchronous discard of all buffered data.
REQ-009 SHALL have port x, output, 1, registered serial bit feeding the downstream sequence detector.
REQ-010 SHALL have port x_valid, output, 1, one-clk pulse marking each newly emitted bit.
REQ-011 SHALL have port word_last, output, 1, one-clk pulse coincident with x_valid for bit DW-1 of a word.
REQ-012 SHALL have port busy, output, 1, high when state is SHIFT or holding register is full.
REQ-013 SHALL have port word_cnt, output, 8, count of fully emitted words, modulo 256.

Function
REQ-014 SHALL contain a DW-bit holding register with hold_full flag, a DW-bit shift register, a bit counter 0..DW-1, and a two-state FSM IDLE/SHIFT.
REQ-015 SHALL set in_ready = ~hold_full; accept in_data into holding register and set hold_full on an edge with in_valid & in_ready & ~abort.
REQ-016 SHALL, in IDLE with hold_full=1, move holding register into shift register, clear hold_full, zero bit counter, enter SHIFT on that edge regardless of tick.
REQ-017 SHALL ignore tick in IDLE: x holds, x_valid=0, word_last=0.
REQ-018 SHALL, in SHIFT on an edge with tick=1, drive x <= shift[DW-1], shift left by one (zero fill), increment bit counter, pulse x_valid (MSB first).
REQ-019 SHALL, in SHIFT on edges with tick=0, hold shift register, counter and x; x_valid=0, word_last=0.
REQ-020 SHALL, on the tick edge emitting bit DW-1, pulse word_last, increment word_cnt (255 wraps to 0), and if hold_full=1 load the holding word, clear hold_full, zero counter, stay SHIFT (no bubble), else return to IDLE.
REQ-021 SHALL never accept and transfer the holding register on the same edge (accept needs hold_full=0, transfer needs hold_full=1).
REQ-022 SHALL, on abort=1, clear hold_full, enter IDLE, zero bit counter, force x_valid=0 and word_last=0, keep x and word_cnt; abort overrides tick and accept on that edge.
REQ-023 SHALL give latency: word accepted at edge E in IDLE, transferred at E+1, MSB emitted at first tick edge after E+1.
REQ-024 SHALL sustain a tick rate of one per clk with back-to-back words producing DW bits per word with no gap.

Reset
REQ-025 SHALL, while rst=0, force FSM IDLE, hold_full=0, shift register 0, bit counter 0, x=0, x_valid=0, word_last=0, word_cnt=0; in_ready=1, busy=0.
REQ-026 SHALL, on rst asserted mid-word, discard the partial word and buffered word with no further x_valid pulses.
REQ-027 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-028 Single word: DW=8, in_data=8'b1011_0000 accepted, tick every clk -> x sequence 1,0,1,1,0,0,0,0 with 8 x_valid pulses, word_last on 8th, word_cnt=1, busy falls after.
REQ-029 Back-to-back: words 8'hB5, 8'h0B offered continuously, tick=1 -> 16 contiguous x_valid pulses, in_ready low while second word held, word_cnt=2.
REQ-030 Sparse tick: tick every 4th clk, word 8'hFF -> x_valid exactly 8 pulses spaced 4 clk apart, x constant 1 between pulses.
REQ-031 Abort: abort after 3 bits of 8'hA5 with 8'h5A held -> no further x_valid, in_ready=1, busy=0, word_cnt unchanged.
REQ-032 Reset mid-word and wrap: rst low after 5 bits -> all outputs to reset values; later 256 words -> word_cnt returns to 0.

Source files
------------

// File: rtl/par2ser_stream_if.sv
// Upstream word channel of the parallel-to-serial stream.
// A word moves on a clk edge where in_valid and in_ready are both high.
// in_valid and in_data stay stable until that edge, and in_ready does not depend on in_valid.
interface par2ser_stream_if #(parameter int DW = 8);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter. Words are emitted MSB first, one bit per tick.
// A one-word holding register sits in front of the shift register, so that
// back-to-back words leave with no gap between them.
module par2ser_stream #(parameter int DW = 8) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             abort,
   par2ser_stream_if.slave  up,
   output logic             x,
   output logic             x_valid,
   output logic             word_last,
   output logic             busy,
   output logic [7:0]       word_cnt,
   output logic             dbg_state
);

   localparam int CW = $clog2(DW);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] hold_q;
   logic          hold_full;
   logic [DW-1:0] shift_q;
   logic [CW-1:0] cnt_q;

   logic accept;
   logic load;
   logic shift_en;
   logic last;

   assign up.in_ready = ~hold_full;
   assign accept      = up.in_valid & ~hold_full & ~abort;
   assign busy        = (state_q == SHIFT) | hold_full;
   assign dbg_state   = state_q;

   // Next-state and per-edge actions. Abort wins over every other action.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      shift_en = 1'b0;
      last     = 1'b0;
      case (state_q)
         IDLE: begin
            if (hold_full) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               shift_en = 1'b1;
               if (cnt_q == CW'(DW - 1)) begin
                  last = 1'b1;
                  if (hold_full) load = 1'b1;
                  else           state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d  = IDLE;
         load     = 1'b0;
         shift_en = 1'b0;
         last     = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Holding register: an accept needs the register empty and a load needs it full, so they never coincide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q    <= '0;
         hold_full <= 1'b0;
      end else if (abort) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_q    <= up.in_data;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   // Shift register and bit counter. The counter restarts on every word boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (load)          shift_q <= hold_q;
         else if (shift_en) shift_q <= {shift_q[DW-2:0], 1'b0};
         if (abort || load || last) cnt_q <= '0;
         else if (shift_en)         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Serial output, bit strobes and completed-word counter. Abort leaves x and word_cnt unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x         <= 1'b0;
         x_valid   <= 1'b0;
         word_last <= 1'b0;
         word_cnt  <= 8'd0;
      end else begin
         if (shift_en) x <= shift_q[DW-1];
         x_valid   <= shift_en;
         word_last <= last;
         if (last) word_cnt <= word_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_par2ser_stream.sv
// Directed bench for par2ser_stream at DW=8. It uses per-cycle vector tables
// for the single-word and abort cases, and hand-written sequences for the
// back-to-back, sparse-tick, reset and wrap cases.
module tb_par2ser_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       abort;
   logic       x, x_valid, word_last, busy, dbg_state;
   logic [7:0] word_cnt;

   par2ser_stream_if #(.DW(8)) up ();

   par2ser_stream #(.DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .abort     (abort),
      .up        (up.slave),
      .x         (x),
      .x_valid   (x_valid),
      .word_last (word_last),
      .busy      (busy),
      .word_cnt  (word_cnt),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        tick;
      logic        iv;
      logic [7:0]  d;
      logic        ab;
      logic [12:0] exp;   // {in_ready, x, x_valid, word_last, busy, word_cnt}
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   logic exp_q[$];

   function automatic vec_t mk(input logic t, input logic iv, input logic [7:0] d, input logic ab,
                               input logic ir, input logic xx, input logic xv, input logic wl,
                               input logic bz, input logic [7:0] c);
      vec_t v;
      v.tick = t; v.iv = iv; v.d = d; v.ab = ab;
      v.exp  = {ir, xx, xv, wl, bz, c};
      return v;
   endfunction

   function automatic logic [12:0] obs();
      return {up.in_ready, x, x_valid, word_last, busy, word_cnt};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive at a negedge, let one rising edge pass, compare at the following negedge.
   task automatic apply(input vec_t v, input string name);
      tick = v.tick; up.in_valid = v.iv; up.in_data = v.d; abort = v.ab;
      @(posedge clk);
      @(negedge clk);
      check(name, 32'(obs()), 32'(v.exp));
   endtask

   task automatic idle_inputs();
      tick = 1'b0; up.in_valid = 1'b0; up.in_data = 8'h00; abort = 1'b0;
   endtask

   vec_t t_single[$];
   vec_t t_abort[$];

   initial begin
      // Single word 1011_0000, tick every clk
      t_single.push_back(mk(1,1,8'hB0,0, 0,0,0,0,1,8'd0)); // accepted
      t_single.push_back(mk(1,0,8'h00,0, 1,0,0,0,1,8'd0)); // transferred, tick ignored in IDLE
      t_single.push_back(mk(1,0,8'h00,0, 1,1,1,0,1,8'd0)); // bit7
      t_single.push_back(mk(1,0,8'h00,0, 1,0,1,0,1,8'd0));
      t_single.push_back(mk(1,0,8'h00,0, 1,1,1,0,1,8'd0));
      t_single.push_back(mk(1,0,8'h00,0, 1,1,1,0,1,8'd0));
      t_single.push_back(mk(1,0,8'h00,0, 1,0,1,0,1,8'd0));
      t_single.push_back(mk(1,0,8'h00,0, 1,0,1,0,1,8'd0));
      t_single.push_back(mk(1,0,8'h00,0, 1,0,1,0,1,8'd0));
      t_single.push_back(mk(1,0,8'h00,0, 1,0,1,1,0,8'd1)); // bit0, word_last
      t_single.push_back(mk(1,0,8'h00,0, 1,0,0,0,0,8'd1)); // idle, tick ignored
      // Abort after 3 bits of A5 with 5A held
      t_abort.push_back(mk(0,1,8'hA5,0, 0,0,0,0,1,8'd1));  // accept A5
      t_abort.push_back(mk(0,1,8'h5A,0, 1,0,0,0,1,8'd1));  // transfer A5
      t_abort.push_back(mk(0,1,8'h5A,0, 0,0,0,0,1,8'd1));  // accept 5A, no tick
      t_abort.push_back(mk(1,0,8'h00,0, 0,1,1,0,1,8'd1));  // bit7 = 1
      t_abort.push_back(mk(1,0,8'h00,0, 0,0,1,0,1,8'd1));  // bit6 = 0
      t_abort.push_back(mk(1,0,8'h00,0, 0,1,1,0,1,8'd1));  // bit5 = 1
      t_abort.push_back(mk(1,0,8'h00,1, 1,1,0,0,0,8'd1));  // abort: x kept
      t_abort.push_back(mk(1,0,8'h00,0, 1,1,0,0,0,8'd1));  // nothing left
      t_abort.push_back(mk(1,1,8'hC3,1, 1,1,0,0,0,8'd1));  // abort blocks accept
   end

   logic [7:0] b2b_w[2] = '{8'hB5, 8'h0B};
   logic       xv_hist[24];
   logic       ir_hist[24];

   initial begin
      int exp_cnt;
      int idx, pulses, wl_n, last_pulse, bad, timeout;
      logic ir_s;
      logic [7:0] w;
      logic eb;

      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({obs(), dbg_state}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}));
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < t_single.size(); i++) apply(t_single[i], $sformatf("single_v%0d", i));
      for (int i = 0; i < t_abort.size(); i++)  apply(t_abort[i],  $sformatf("abort_v%0d", i));
      idle_inputs();
      exp_cnt = 1;

      // Back-to-back B5, 0B with tick every clk
      exp_q.delete();
      w = 8'hB5; for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
      w = 8'h0B; for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
      idx = 0; wl_n = 0;
      for (int c = 0; c < 24; c++) begin
         tick = 1'b1;
         up.in_valid = (idx < 2);
         up.in_data  = (idx < 2) ? b2b_w[idx] : 8'h00;
         ir_s = up.in_ready;
         @(posedge clk);
         @(negedge clk);
         if (up.in_valid && ir_s) idx++;
         xv_hist[c] = x_valid;
         ir_hist[c] = up.in_ready;
         if (word_last) wl_n++;
         if (x_valid) begin
            if (exp_q.size() == 0) check("b2b_extra_bit", 32'(1), 32'(0));
            else begin
               eb = exp_q.pop_front();
               check($sformatf("b2b_bit_c%0d", c), 32'(x), 32'(eb));
            end
         end
      end
      idle_inputs();
      pulses = 0;
      for (int c = 2; c <= 17; c++) if (xv_hist[c]) pulses++;
      check("b2b_contiguous_pulses", 32'(pulses), 32'(16));
      pulses = 0;
      for (int c = 0; c < 24; c++) if (xv_hist[c]) pulses++;
      check("b2b_total_pulses", 32'(pulses), 32'(16));
      check("b2b_word_last_cnt", 32'(wl_n), 32'(2));
      check("b2b_ready_low_held", 32'({ir_hist[2], ir_hist[8], ir_hist[9]}), 32'(3'b001));
      exp_cnt += 2;
      check("b2b_word_cnt", 32'(word_cnt), 32'(exp_cnt));
      check("b2b_busy_after", 32'(busy), 32'(0));

      // Sparse tick: FF with tick every 4th clk
      up.in_valid = 1'b1; up.in_data = 8'hFF; tick = 1'b0;
      @(posedge clk); @(negedge clk);
      idle_inputs();
      pulses = 0; wl_n = 0; last_pulse = -1; bad = 0;
      for (int c = 0; c < 40; c++) begin
         tick = ((c % 4) == 3);
         @(posedge clk); @(negedge clk);
         if (x_valid) begin
            if (last_pulse >= 0 && (c - last_pulse) != 4) bad++;
            last_pulse = c;
            pulses++;
         end
         if (word_last) wl_n++;
         if (pulses > 0 && x !== 1'b1) bad++;
      end
      idle_inputs();
      check("sparse_pulses", 32'(pulses), 32'(8));
      check("sparse_spacing_and_x", 32'(bad), 32'(0));
      check("sparse_word_last", 32'(wl_n), 32'(1));
      exp_cnt += 1;
      check("sparse_word_cnt", 32'(word_cnt), 32'(exp_cnt));

      // Reset after 5 bits of F0 with 0F buffered
      up.in_valid = 1'b1; up.in_data = 8'hF0; tick = 1'b1;
      @(posedge clk); @(negedge clk);
      up.in_data = 8'h0F;
      repeat (6) begin @(posedge clk); @(negedge clk); end
      up.in_valid = 1'b0;
      check("pre_reset_busy_full", 32'({busy, up.in_ready}), 32'(2'b10));
      rst = 1'b0;
      #1;
      check("reset_mid_word", 32'({obs(), dbg_state}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}));
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); @(negedge clk);
         if (x_valid || busy) pulses++;
      end
      check("post_reset_quiet", 32'(pulses), 32'(0));
      exp_cnt = 0;

      // 256 back-to-back words: word_cnt passes 255 and wraps to 0
      idx = 0; wl_n = 0; timeout = 0;
      tick = 1'b1;
      while ((idx < 256 || busy) && timeout < 4000) begin
         up.in_valid = (idx < 256);
         up.in_data  = 8'(idx);
         ir_s = up.in_ready;
         @(posedge clk); @(negedge clk);
         if (up.in_valid && ir_s) idx++;
         if (word_last) begin
            wl_n++;
            if (wl_n == 255) check("wrap_cnt_255", 32'(word_cnt), 32'(255));
         end
         timeout++;
      end
      idle_inputs();
      check("wrap_timeout", 32'(timeout < 4000), 32'(1));
      check("wrap_word_last_cnt", 32'(wl_n), 32'(256));
      check("wrap_word_cnt", 32'(word_cnt), 32'(exp_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
